ram_block_reader: RTL and testbench
===================================

Name: ram_block_reader

Overview:
- Sequencer that reads a block of words out of the team's 32-bit RAM through its read port (OutSel / Output).
- Streams the words to a downstream consumer over a valid/ready handshake.
- Counterpart of the strided writer pattern used to fill the RAM: walks addresses BaseAddr, BaseAddr+Stride, ... for Count words, then pulses Done.
- Sits between the RAM read port and any consumer stage (checker, ALU feed, output port).

Parameters:
ADDR_WIDTH, 8, RAM address width; matches the RAM's InSel/OutSel.
DATA_WIDTH, 32, RAM word width.
CNT_WIDTH, 9, width of Count; ADDR_WIDTH+1 so a full 256-word pass is expressible.

Ports:
Clock  input  1  system clock, rising-edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  single-cycle request to begin a block read; sampled only in IDLE.
BaseAddr  input  ADDR_WIDTH  first RAM address; latched on accepted Start.
Stride  input  ADDR_WIDTH  address increment per word; latched on accepted Start.
Count  input  CNT_WIDTH  number of words to read; latched on accepted Start.
OutSel  output  ADDR_WIDTH  RAM read address; drive to RAM OutSel.
RamData  input  DATA_WIDTH  RAM Output; asynchronous read, valid in the same cycle OutSel is driven.
DataOut  output  DATA_WIDTH  registered word to the consumer.
DataValid  output  1  DataOut holds an unaccepted word.
DataReady  input  1  consumer accepts DataOut when DataValid&&DataReady at a rising edge.
Busy  output  1  high from the cycle after an accepted Start until the DONE state.
Done  output  1  one-cycle pulse after the final word is accepted, or after a Count=0 start.

Behaviour:
- Reset (synchronous, Clock edge with Reset=1):
  - state=IDLE; OutSel=0, DataOut=0, DataValid=0, Busy=0, Done=0; internal address/remaining count cleared.
  - Reset overrides every other input in the same cycle.
- FSM states: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - Start=1 latches BaseAddr, Stride and Count into internal address register addr and remaining counter rem.
  - Next state is FETCH if Count!=0, otherwise DONE.
- FETCH (1 cycle):
  - OutSel=addr, Busy=1.
  - At the edge: DataOut<=RamData, DataValid<=1, addr<=addr+Stride, rem<=rem-1, next state HOLD.
- HOLD:
  - DataValid=1; DataOut stable until accepted.
  - Handshake at the edge: DataValid<=0; next state FETCH if rem!=0, else DONE.
  - No handshake: remain in HOLD.
- DONE (1 cycle): Done=1, Busy=0, next state IDLE.
- Throughput: 2 cycles per word with DataReady held high. An N-word block from Start sampled at edge 0 gives Done high in cycle 2N+1.
- Address arithmetic:
  - Modulo 2^ADDR_WIDTH; wraps silently (248+8 -> 0).
  - Stride=0 is legal and rereads the same word Count times.
- OutSel holds its last value outside FETCH.
- Start while not in IDLE is ignored. Latched parameters are unaffected.
- Reset during FETCH/HOLD aborts the block: no Done pulse; any pending word is discarded (DataValid=0).
- DataReady while DataValid=0 has no effect.

Optional Feature:
- Macro: RAM_BLOCK_READER_CHECKSUM_EN.
- Defined:
  - Adds output port Checksum (DATA_WIDTH): sum modulo 2^DATA_WIDTH of every word accepted by handshake in the current block.
  - Cleared to 0 on accepted Start and on Reset.
  - Holds its final value through DONE and IDLE until the next accepted Start.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- RAM preloaded mem[a]=a*256; Base=0, Stride=8, Count=4, DataReady=1.
  -> OutSel sequence 0,8,16,24.
  -> DataOut accepted 0,2048,4096,6144.
  -> Done high in cycle 9 only; Busy high cycles 1-8.
- Wrap: Base=248, Stride=8, Count=3.
  -> OutSel 248,0,8.
  -> DataOut 63488,0,2048; Done once.
- Backpressure: Base=0, Stride=8, Count=2; DataReady low for 5 cycles after the first DataValid.
  -> DataOut stays 0 with DataValid high all 5 cycles.
  -> OutSel does not advance to 8 until acceptance.
  -> Second word is 2048.
- Count=0 start.
  -> Done pulses in cycle 1.
  -> DataValid never asserts; Busy stays 0.
- Start pulsed again mid-block (Base=100).
  -> Ignored; the block completes from the original Base.
- Reset asserted in HOLD of word 2 of 4.
  -> Next cycle all outputs 0, state IDLE, no Done.
  -> A new Start runs normally.
- With RAM_BLOCK_READER_CHECKSUM_EN defined, first scenario.
  -> Checksum=12288 at Done; still 12288 ten cycles later; 0 after the next Start.

Source files
------------

// File: rtl/ram_block_reader_if.sv
// Read-sequencer bus: block request, RAM read port, and the word stream to the consumer.
// Signals: Start/BaseAddr/Stride/Count (request), OutSel/RamData (RAM read port),
//          DataOut/DataValid/DataReady (consumer), Busy/Done (status), Checksum when
//          RAM_BLOCK_READER_CHECKSUM_EN is defined.
interface ram_block_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 9
);
    logic                  Start;
    logic [ADDR_WIDTH-1:0] BaseAddr;
    logic [ADDR_WIDTH-1:0] Stride;
    logic [CNT_WIDTH-1:0]  Count;
    logic [ADDR_WIDTH-1:0] OutSel;
    logic [DATA_WIDTH-1:0] RamData;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  DataValid;
    logic                  DataReady;
    logic                  Busy;
    logic                  Done;
`ifdef RAM_BLOCK_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] Checksum;
`endif

    // Reader side.
    modport master (
        input  Start, BaseAddr, Stride, Count, RamData, DataReady,
`ifdef RAM_BLOCK_READER_CHECKSUM_EN
        output Checksum,
`endif
        output OutSel, DataOut, DataValid, Busy, Done
    );

    // Requester / RAM / consumer side.
    modport slave (
        output Start, BaseAddr, Stride, Count, RamData, DataReady,
`ifdef RAM_BLOCK_READER_CHECKSUM_EN
        input  Checksum,
`endif
        input  OutSel, DataOut, DataValid, Busy, Done
    );
endinterface

// File: rtl/ram_block_reader.sv
// Purpose: walks RAM addresses Base, Base+Stride, ... for Count words and streams them out.
// Latency: word on DataOut one cycle after its FETCH; 2 cycles/word with DataReady high.
// Backpressure: holds the word in HOLD until DataValid&&DataReady; no further fetch until then.
// Ports: Clock, Reset (sync, active-high); bus (ram_block_reader_if.master) carries the
//        request, RAM read port, consumer handshake and Busy/Done status.
// Option: RAM_BLOCK_READER_CHECKSUM_EN adds Checksum = sum of words accepted in this block.
module ram_block_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 9
) (
    input  logic               Clock,
    input  logic               Reset,
    ram_block_reader_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] outsel_q, outsel_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvld_q, dvld_d;
    logic                  handshake;

    assign handshake = dvld_q && bus.DataReady;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        outsel_d = outsel_q;
        rem_d    = rem_q;
        dout_d   = dout_q;
        dvld_d   = dvld_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    addr_d   = bus.BaseAddr;
                    stride_d = bus.Stride;
                    rem_d    = bus.Count;
                    state_d  = (bus.Count != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                // RAM read is asynchronous: RamData is the word at addr_q this cycle.
                outsel_d = addr_q;
                dout_d   = bus.RamData;
                dvld_d   = 1'b1;
                addr_d   = addr_q + stride_q;
                rem_d    = rem_q - CNT_WIDTH'(1);
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    dvld_d  = 1'b0;
                    state_d = (rem_q != '0) ? S_FETCH : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            outsel_q <= '0;
            rem_q    <= '0;
            dout_q   <= '0;
            dvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            outsel_q <= outsel_d;
            rem_q    <= rem_d;
            dout_q   <= dout_d;
            dvld_q   <= dvld_d;
        end
    end

    // OutSel shows the live address while fetching and otherwise holds the last one read.
    assign bus.OutSel    = (state_q == S_FETCH) ? addr_q : outsel_q;
    assign bus.DataOut   = dout_q;
    assign bus.DataValid = dvld_q;
    assign bus.Busy      = (state_q == S_FETCH) || (state_q == S_HOLD);
    assign bus.Done      = (state_q == S_DONE);

`ifdef RAM_BLOCK_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == S_IDLE && bus.Start) begin
            sum_d = '0;
        end else if (state_q == S_HOLD && handshake) begin
            sum_d = sum_q + dout_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.Checksum = sum_q;
`endif
endmodule

// File: tb/tb_ram_block_reader.sv
module tb_ram_block_reader;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_block_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    ram_block_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Behavioural RAM with asynchronous read.
    logic [DW-1:0] mem [256];
    assign bus.RamData = mem[bus.OutSel];

    logic rdy_rand, rdy_val, rnd_bit;
    assign bus.DataReady = rdy_rand ? rnd_bit : rdy_val;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] word_q [$];
    logic [DW-1:0] exp_sum;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (unexpected event or timeout)", name);
    endtask

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: FETCH cycles (Busy without a held word) must present the next expected
    // address; every handshake must carry the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.Busy && !bus.DataValid) begin
                    if (addr_q.size() == 0) fail("outsel_extra");
                    else chk("outsel", bus.OutSel, addr_q.pop_front());
                end
                if (bus.DataValid && bus.DataReady) begin
                    if (word_q.size() == 0) fail("word_extra");
                    else chk("dataout", bus.DataOut, word_q.pop_front());
                end
                if (bus.Done) done_seen++;
            end
        end
    end

    task automatic expect_block(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int cnt);
        logic [AW-1:0] a;
        exp_sum = '0;
        for (int i = 0; i < cnt; i++) begin
            a = AW'((int'(base) + i * int'(stride)) % 256);
            addr_q.push_back(a);
            word_q.push_back(mem[a]);
            exp_sum += mem[a];
        end
    endtask

    // Entered just after a rising edge; Start is sampled at the next edge (edge 0).
    task automatic run_block(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input int cnt, input bit timing, input bit mid);
        int cyc, busy_cnt, dv_cnt, done_before;
        bit seen;
        expect_block(base, stride, cnt);
        done_before = done_seen;
        bus.Start = 1'b1; bus.BaseAddr = base; bus.Stride = stride; bus.Count = CW'(cnt);
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.BaseAddr = AW'($urandom); bus.Stride = AW'($urandom); bus.Count = CW'($urandom);
        cyc = 0; busy_cnt = 0; dv_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.Busy) busy_cnt++;
            if (bus.DataValid) dv_cnt++;
`ifdef RAM_BLOCK_READER_CHECKSUM_EN
            if (cyc == 1) chk("checksum_cleared", bus.Checksum, 0);
`endif
            if (bus.Done) seen = 1'b1;
            else if (mid && cyc == 3) begin bus.Start = 1'b1; bus.BaseAddr = 8'd100; end
            else if (mid && cyc == 4) bus.Start = 1'b0;
        end
        bus.Start = 1'b0;
        if (!seen) begin
            fail("done_timeout");
        end else begin
            if (timing) begin
                chk("done_cycle", cyc, 2 * cnt + 1);
                chk("busy_cycles", busy_cnt, 2 * cnt);
                chk("valid_cycles", dv_cnt, cnt);
            end
`ifdef RAM_BLOCK_READER_CHECKSUM_EN
            chk("checksum_at_done", bus.Checksum, exp_sum);
`endif
            @(negedge clk);
            chk("done_one_cycle", bus.Done, 0);
            chk("done_count", done_seen - done_before, 1);
            chk("words_left", word_q.size(), 0);
            chk("addrs_left", addr_q.size(), 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int done_before, k;
        bit mid;
        rst = 1'b1; bus.Start = 1'b0; bus.BaseAddr = '0; bus.Stride = '0; bus.Count = '0;
        rdy_rand = 1'b0; rdy_val = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = DW'(a * 256);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outsel", bus.OutSel, 0);
        chk("rst_dataout", bus.DataOut, 0);
        chk("rst_valid", bus.DataValid, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic block: 0,8,16,24 -> 0,2048,4096,6144.
        run_block(8'd0, 8'd8, 4, 1'b1, 1'b0);
`ifdef RAM_BLOCK_READER_CHECKSUM_EN
        chk("checksum_basic", bus.Checksum, 12288);
        repeat (10) @(negedge clk);
        chk("checksum_hold", bus.Checksum, 12288);
        @(posedge clk); #1;
`endif

        // Address wrap: 248,0,8.
        run_block(8'd248, 8'd8, 3, 1'b1, 1'b0);

        // Backpressure: first word held for 5 cycles.
        rdy_val = 1'b0;
        expect_block(8'd0, 8'd8, 2);
        done_before = done_seen;
        bus.Start = 1'b1; bus.BaseAddr = 8'd0; bus.Stride = 8'd8; bus.Count = 9'd2;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", bus.DataValid, 1);
            chk("bp_data", bus.DataOut, 0);
            chk("bp_outsel", bus.OutSel, 0);
        end
        @(posedge clk); #1;
        rdy_val = 1'b1;
        k = 0;
        while (done_seen == done_before && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_done_count", done_seen - done_before, 1);
        chk("bp_words_left", word_q.size(), 0);
        @(posedge clk); #1;

        // Empty block and ignored mid-block Start.
        run_block(8'd0, 8'd8, 0, 1'b1, 1'b0);
        run_block(8'd0, 8'd8, 4, 1'b1, 1'b1);

        // Reset while holding word 2 of 4.
        addr_q.push_back(8'd0); addr_q.push_back(8'd8);
        word_q.push_back(mem[0]);
        done_before = done_seen;
        bus.Start = 1'b1; bus.BaseAddr = 8'd0; bus.Stride = 8'd8; bus.Count = 9'd4;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_hold_valid", bus.DataValid, 1);
        chk("abort_hold_data", bus.DataOut, 2048);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outsel", bus.OutSel, 0);
        chk("abort_dataout", bus.DataOut, 0);
        chk("abort_valid", bus.DataValid, 0);
        chk("abort_busy", bus.Busy, 0);
        chk("abort_done", bus.Done, 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_seen - done_before, 0);
        chk("abort_words_left", word_q.size(), 0);
        chk("abort_addrs_left", addr_q.size(), 0);
        rdy_val = 1'b1;
        @(posedge clk); #1;
        run_block(8'd16, 8'd4, 3, 1'b1, 1'b0);

        // Randomized blocks with random backpressure; first one is a full 256-word pass.
        rdy_rand = 1'b1;
        for (int b = 0; b < 20; b++) begin
            int cnt;
            logic [AW-1:0] base, stride;
            for (int a = 0; a < 256; a++) mem[a] = $urandom;
            cnt    = (b == 0) ? 256 : int'($urandom_range(0, 12));
            stride = (b == 0) ? 8'd1 : AW'($urandom);
            base   = AW'($urandom);
            mid    = (cnt >= 2) && ($urandom_range(0, 3) == 0);
            run_block(base, stride, cnt, 1'b0, mid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
